// File: rtl/du_pkg.sv
// rtl/du_pkg.sv - command/response codes and state encoding for the debug-unit master
package du_pkg;

    localparam logic [7:0] CMD_SOT   = 8'h01;
    localparam logic [7:0] CMD_CONT  = 8'h01;
    localparam logic [7:0] CMD_STEP  = 8'h02;
    localparam logic [7:0] CMD_STEP1 = 8'h03;
    localparam logic [7:0] CMD_EOT   = 8'h04;

    localparam logic [7:0] RSP_ACK       = 8'h05;
    localparam logic [7:0] RSP_NAK       = 8'h15;
    localparam logic [7:0] RSP_HEARTBEAT = 8'h2A;

    typedef enum logic [8:0] {
        ST_IDLE      = 9'b0_0000_0001,
        ST_LOAD_FW   = 9'b0_0000_0010,
        ST_MODE_SEL  = 9'b0_0000_0100,
        ST_CONT_RUN  = 9'b0_0000_1000,
        ST_STEP_WAIT = 9'b0_0001_0000,
        ST_STEP_EXEC = 9'b0_0010_0000,
        ST_DUMP_REGS = 9'b0_0100_0000,
        ST_DUMP_DMEM = 9'b0_1000_0000,
        ST_DONE      = 9'b1_0000_0000
    } du_state_e;

endpackage

// File: rtl/du_timer.sv
// rtl/du_timer.sv - loadable up-counter with clear, terminal-count compare and wrap
module du_timer #(
    parameter int NB_COUNTER = 32
) (
    input  logic                  clk,
    input  logic                  i_rst_n,
    input  logic                  i_clr,
    input  logic                  i_en,
    input  logic                  i_load,
    input  logic [NB_COUNTER-1:0] i_load_val,
    input  logic [NB_COUNTER-1:0] i_terminal,
    output logic                  o_tc
);

    logic [NB_COUNTER-1:0] count;

    assign o_tc = (count == i_terminal);

    // Clear outranks load so a state entry always restarts from zero.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count <= '0;
        end else if (i_clr) begin
            count <= '0;
        end else if (i_load) begin
            count <= i_load_val;
        end else if (i_en) begin
            count <= o_tc ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/du_master_ctrl.sv
// rtl/du_master_ctrl.sv - debug-unit master: firmware load, run/step control, halt dumps
module du_master_ctrl
    import du_pkg::*;
#(
    parameter int                         NB_INSTRUCTION   = 32,
    parameter int                         NB_UART_DATA     = 8,
    parameter int                         NB_COUNTER       = 32,
    parameter int                         HEARTBEAT_CYCLES = 400_000_000,
    parameter int                         RUN_LIMIT        = 0,
    parameter logic [NB_INSTRUCTION-1:0]  HALT_INSTR       = 32'h1A1A1A1A
) (
    input  logic                      clk,
    input  logic                      i_rst_n,
    input  logic [NB_INSTRUCTION-1:0] i_instr,
    input  logic [NB_UART_DATA-1:0]   i_rx_data,
    input  logic                      i_rx_done,
    input  logic                      i_tx_done,
    input  logic                      i_loader_done,
    input  logic                      i_send_regs_done,
    input  logic                      i_send_dmem_done,
    output logic                      o_cpu_en,
    output logic                      o_load_start,
    output logic                      o_send_regs_start,
    output logic                      o_send_dmem_start,
    output logic                      o_rd,
    output logic                      o_wr,
    output logic                      o_tx_start,
    output logic [NB_UART_DATA-1:0]   o_wdata,
    output logic                      o_halted
);

    localparam logic [NB_UART_DATA-1:0] SOT   = NB_UART_DATA'(CMD_SOT);
    localparam logic [NB_UART_DATA-1:0] CONT  = NB_UART_DATA'(CMD_CONT);
    localparam logic [NB_UART_DATA-1:0] STEP  = NB_UART_DATA'(CMD_STEP);
    localparam logic [NB_UART_DATA-1:0] STEP1 = NB_UART_DATA'(CMD_STEP1);
    localparam logic [NB_UART_DATA-1:0] EOT   = NB_UART_DATA'(CMD_EOT);
    localparam logic [NB_UART_DATA-1:0] ACK   = NB_UART_DATA'(RSP_ACK);
    localparam logic [NB_UART_DATA-1:0] NAK   = NB_UART_DATA'(RSP_NAK);
    localparam logic [NB_UART_DATA-1:0] HBEAT = NB_UART_DATA'(RSP_HEARTBEAT);

    localparam logic [NB_COUNTER-1:0] HB_TERM = NB_COUNTER'(HEARTBEAT_CYCLES - 1);
    localparam logic [NB_COUNTER-1:0] WD_TERM = NB_COUNTER'(RUN_LIMIT - 1);

    du_state_e state;
    du_state_e state_nxt;

    logic                    halt_flag;
    logic                    halt_set;
    logic                    halt_clr;
    logic                    resp_vld;
    logic [NB_UART_DATA-1:0] resp_byte;
    logic                    hb_tc;
    logic                    wd_tc;
    logic                    hb_fire;
    logic                    wd_expire;
    logic                    halt_seen;
    logic                    rx_state;
    logic                    state_chg;
    logic [NB_UART_DATA-1:0] hb_byte;
    logic                    pend_vld;
    logic                    pend_rsp;
    logic [NB_UART_DATA-1:0] pend_byte;
    logic                    tx_vld;
    logic                    tx_rsp;
    logic [NB_UART_DATA-1:0] tx_byte;

    assign halt_seen = (i_instr == HALT_INSTR);
    assign rx_state  = state inside {ST_IDLE, ST_MODE_SEL, ST_STEP_WAIT, ST_DONE};
    assign wd_expire = (RUN_LIMIT != 0) && (state == ST_CONT_RUN) && wd_tc;
    assign hb_fire   = hb_tc && (state inside {ST_IDLE, ST_MODE_SEL}) && !i_rx_done;
    assign hb_byte   = (state == ST_IDLE) ? NAK : HBEAT;
    assign state_chg = (state_nxt != state);

    du_timer #(.NB_COUNTER(NB_COUNTER)) u_hb_timer (
        .clk        (clk),
        .i_rst_n    (i_rst_n),
        .i_clr      (state_chg),
        .i_en       (1'b1),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_terminal (HB_TERM),
        .o_tc       (hb_tc)
    );

    du_timer #(.NB_COUNTER(NB_COUNTER)) u_wd_timer (
        .clk        (clk),
        .i_rst_n    (i_rst_n),
        .i_clr      (state_chg),
        .i_en       (state == ST_CONT_RUN),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_terminal (WD_TERM),
        .o_tc       (wd_tc)
    );

    always_comb begin
        state_nxt = state;
        halt_set  = 1'b0;
        halt_clr  = 1'b0;
        resp_vld  = 1'b0;
        resp_byte = '0;
        case (state)
            ST_IDLE: begin
                if (i_rx_done && i_rx_data == SOT) state_nxt = ST_LOAD_FW;
            end
            ST_LOAD_FW: begin
                if (i_loader_done) state_nxt = ST_MODE_SEL;
            end
            ST_MODE_SEL: begin
                if (i_rx_done) begin
                    resp_vld = 1'b1;
                    if (i_rx_data == CONT) begin
                        resp_byte = ACK;
                        state_nxt = ST_CONT_RUN;
                    end else if (i_rx_data == STEP) begin
                        resp_byte = ACK;
                        state_nxt = ST_STEP_WAIT;
                    end else begin
                        resp_byte = NAK;
                    end
                end
            end
            ST_CONT_RUN: begin
                // A real halt on the expiry cycle wins and suppresses the watchdog NAK.
                if (halt_seen) begin
                    state_nxt = ST_DUMP_REGS;
                    halt_set  = 1'b1;
                end else if (wd_expire) begin
                    resp_vld  = 1'b1;
                    resp_byte = NAK;
                    state_nxt = ST_DUMP_REGS;
                    halt_set  = 1'b1;
                end
            end
            ST_STEP_WAIT: begin
                if (i_rx_done) begin
                    if (i_rx_data == STEP1) begin
                        state_nxt = ST_STEP_EXEC;
                    end else if (i_rx_data == CONT) begin
                        resp_vld  = 1'b1;
                        resp_byte = ACK;
                        state_nxt = ST_CONT_RUN;
                    end else if (i_rx_data == EOT) begin
                        state_nxt = ST_DUMP_REGS;
                        halt_set  = 1'b1;
                    end else begin
                        resp_vld  = 1'b1;
                        resp_byte = NAK;
                    end
                end
            end
            ST_STEP_EXEC: begin
                state_nxt = ST_DUMP_REGS;
                halt_set  = halt_seen;
            end
            ST_DUMP_REGS: begin
                if (i_send_regs_done) state_nxt = halt_flag ? ST_DUMP_DMEM : ST_STEP_WAIT;
            end
            ST_DUMP_DMEM: begin
                if (i_send_dmem_done) begin
                    state_nxt = ST_DONE;
                    halt_clr  = 1'b1;
                end
            end
            ST_DONE: begin
                if (i_rx_done) begin
                    if (i_rx_data == SOT) begin
                        state_nxt = ST_LOAD_FW;
                    end else begin
                        resp_vld  = 1'b1;
                        resp_byte = NAK;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // One-byte holding slot: fresh responses beat everything, a held response beats a heartbeat.
    always_comb begin
        tx_vld  = 1'b0;
        tx_rsp  = 1'b0;
        tx_byte = '0;
        if (resp_vld) begin
            tx_vld  = 1'b1;
            tx_rsp  = 1'b1;
            tx_byte = resp_byte;
        end else if (pend_vld && pend_rsp) begin
            tx_vld  = 1'b1;
            tx_rsp  = 1'b1;
            tx_byte = pend_byte;
        end else if (hb_fire) begin
            tx_vld  = 1'b1;
            tx_byte = hb_byte;
        end else if (pend_vld) begin
            tx_vld  = 1'b1;
            tx_byte = pend_byte;
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= ST_IDLE;
            halt_flag <= 1'b0;
            pend_vld  <= 1'b0;
            pend_rsp  <= 1'b0;
            pend_byte <= '0;
        end else begin
            state <= state_nxt;
            if (halt_set) begin
                halt_flag <= 1'b1;
            end else if (halt_clr) begin
                halt_flag <= 1'b0;
            end
            pend_vld  <= tx_vld && !i_tx_done;
            pend_rsp  <= tx_rsp;
            pend_byte <= tx_byte;
        end
    end

    assign o_cpu_en          = ((state == ST_CONT_RUN) && !(wd_expire && !halt_seen))
                             || (state == ST_STEP_EXEC);
    assign o_load_start      = (state == ST_LOAD_FW);
    assign o_send_regs_start = (state == ST_DUMP_REGS);
    assign o_send_dmem_start = (state == ST_DUMP_DMEM);
    assign o_halted          = (state == ST_DONE);
    assign o_rd              = i_rx_done && rx_state;
    assign o_wr              = tx_vld && i_tx_done;
    assign o_tx_start        = o_wr;
    assign o_wdata           = o_wr ? tx_byte : '0;

endmodule

// File: tb/tb_du_master_ctrl.sv
// tb/tb_du_master_ctrl.sv - randomized self-checking bench with behavioural model for du_master_ctrl
module tb_du_master_ctrl;

    localparam int          HB   = 10;
    localparam int          RL   = 20;
    localparam logic [31:0] HALT = 32'h1A1A1A1A;

    localparam int M_IDLE = 0, M_LOAD = 1, M_MODE = 2, M_RUN = 3, M_SWAIT = 4,
                   M_EXEC = 5, M_REGS = 6, M_DMEM = 7, M_DONE = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = '0;
    logic [7:0]  rx_data = '0;
    logic        rx_done = 1'b0;
    logic        tx_done = 1'b0;
    logic        ld_done = 1'b0;
    logic        rg_done = 1'b0;
    logic        dm_done = 1'b0;

    logic        o_cpu_en, o_load_start, o_send_regs_start, o_send_dmem_start;
    logic        o_rd, o_wr, o_tx_start, o_halted;
    logic [7:0]  o_wdata;

    always #5 clk = ~clk;

    du_master_ctrl #(
        .NB_INSTRUCTION   (32),
        .NB_UART_DATA     (8),
        .NB_COUNTER       (32),
        .HEARTBEAT_CYCLES (HB),
        .RUN_LIMIT        (RL),
        .HALT_INSTR       (HALT)
    ) dut (
        .clk               (clk),
        .i_rst_n           (rst_n),
        .i_instr           (instr),
        .i_rx_data         (rx_data),
        .i_rx_done         (rx_done),
        .i_tx_done         (tx_done),
        .i_loader_done     (ld_done),
        .i_send_regs_done  (rg_done),
        .i_send_dmem_done  (dm_done),
        .o_cpu_en          (o_cpu_en),
        .o_load_start      (o_load_start),
        .o_send_regs_start (o_send_regs_start),
        .o_send_dmem_start (o_send_dmem_start),
        .o_rd              (o_rd),
        .o_wr              (o_wr),
        .o_tx_start        (o_tx_start),
        .o_wdata           (o_wdata),
        .o_halted          (o_halted)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model: mode, cycles since mode entry, run cycles, held byte (-1 none)
    int m_mode, m_hb, m_run, m_pend;
    bit m_pend_rsp, m_halt;

    int cyc;
    int cpu_cnt;
    int last_wr;
    int wr_cyc[$];
    int wr_bytes[$];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_hb = 0; m_run = 0; m_pend = -1; m_pend_rsp = 0; m_halt = 0;
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [31:0] v;
        v = $urandom;
        if (v == HALT) v = 32'h0;
        return v;
    endfunction

    // One clock cycle: inputs already driven; sample and check at negedge, return at posedge+1.
    task automatic step();
        int nxt, rsp, hb, snd;
        bit consume, halt_now, wd, set_h, clr_h, sr, wr, cpu;
        logic [15:0] e, a;
        @(negedge clk);
        if (!rst_n) begin
            model_reset();
            e   = '0;
            cyc = 0;
        end else begin
            consume  = rx_done && (m_mode == M_IDLE || m_mode == M_MODE ||
                                   m_mode == M_SWAIT || m_mode == M_DONE);
            halt_now = (instr == HALT);
            wd       = (m_mode == M_RUN) && (m_run == RL - 1);
            nxt = m_mode; rsp = -1; set_h = 0; clr_h = 0;
            case (m_mode)
                M_IDLE: if (rx_done && rx_data == 8'h01) nxt = M_LOAD;
                M_LOAD: if (ld_done) nxt = M_MODE;
                M_MODE: if (rx_done) begin
                    if (rx_data == 8'h01) begin rsp = 8'h05; nxt = M_RUN; end
                    else if (rx_data == 8'h02) begin rsp = 8'h05; nxt = M_SWAIT; end
                    else rsp = 8'h15;
                end
                M_RUN: begin
                    if (halt_now) begin nxt = M_REGS; set_h = 1; end
                    else if (wd) begin rsp = 8'h15; nxt = M_REGS; set_h = 1; end
                end
                M_SWAIT: if (rx_done) begin
                    if (rx_data == 8'h03) nxt = M_EXEC;
                    else if (rx_data == 8'h01) begin rsp = 8'h05; nxt = M_RUN; end
                    else if (rx_data == 8'h04) begin nxt = M_REGS; set_h = 1; end
                    else rsp = 8'h15;
                end
                M_EXEC: begin nxt = M_REGS; set_h = halt_now; end
                M_REGS: if (rg_done) nxt = m_halt ? M_DMEM : M_SWAIT;
                M_DMEM: if (dm_done) begin nxt = M_DONE; clr_h = 1; end
                M_DONE: if (rx_done) begin
                    if (rx_data == 8'h01) nxt = M_LOAD;
                    else rsp = 8'h15;
                end
                default: ;
            endcase
            hb = -1;
            if ((m_mode == M_IDLE || m_mode == M_MODE) && m_hb == HB - 1 && !rx_done)
                hb = (m_mode == M_IDLE) ? 8'h15 : 8'h2A;
            snd = -1; sr = 0;
            if (rsp >= 0) begin snd = rsp; sr = 1; end
            else if (m_pend >= 0 && m_pend_rsp) begin snd = m_pend; sr = 1; end
            else if (hb >= 0) snd = hb;
            else if (m_pend >= 0) snd = m_pend;
            wr  = tx_done && (snd >= 0);
            cpu = (m_mode == M_RUN && !(wd && !halt_now)) || (m_mode == M_EXEC);
            e = {cpu, m_mode == M_LOAD, m_mode == M_REGS, m_mode == M_DMEM, consume,
                 wr, wr, m_mode == M_DONE, 8'(wr ? snd : 0)};
            if (tx_done) m_pend = -1;
            else begin m_pend = snd; m_pend_rsp = sr; end
            m_hb  = (nxt != m_mode || m_hb == HB - 1) ? 0 : m_hb + 1;
            m_run = (m_mode == M_RUN && nxt == M_RUN) ? m_run + 1 : 0;
            if (set_h) m_halt = 1; else if (clr_h) m_halt = 0;
            m_mode = nxt;
        end
        a = {o_cpu_en, o_load_start, o_send_regs_start, o_send_dmem_start, o_rd,
             o_wr, o_tx_start, o_halted, o_wdata};
        chk("outputs", int'(a), int'(e));
        last_wr = o_wr ? int'(o_wdata) : -1;
        if (rst_n) begin
            if (o_cpu_en) cpu_cnt++;
            if (o_wr) begin wr_cyc.push_back(cyc); wr_bytes.push_back(int'(o_wdata)); end
            cyc++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send(input logic [7:0] b);
        rx_data = b; rx_done = 1'b1;
        step();
        rx_done = 1'b0; rx_data = 8'($urandom);
    endtask

    task automatic pulse_ld(); ld_done = 1'b1; step(); ld_done = 1'b0; endtask
    task automatic pulse_rg(); rg_done = 1'b1; step(); rg_done = 1'b0; endtask
    task automatic pulse_dm(); dm_done = 1'b1; step(); dm_done = 1'b0; endtask

    initial begin
        model_reset();
        cyc = 0; cpu_cnt = 0; last_wr = -1;

        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1; tx_done = 1'b1;
        wr_cyc.delete(); wr_bytes.delete();
        idle(32);
        chk("idle_hb_count", wr_cyc.size(), 3);
        if (wr_cyc.size() == 3) begin
            chk("idle_hb_cyc0", wr_cyc[0], 9);
            chk("idle_hb_cyc1", wr_cyc[1], 19);
            chk("idle_hb_cyc2", wr_cyc[2], 29);
            chk("idle_hb_byte", wr_bytes[0], 8'h15);
        end

        send(8'h01);
        idle(4);
        pulse_ld();
        send(8'h7F);
        chk("nak_bad_cmd", last_wr, 8'h15);
        tx_done = 1'b0;
        send(8'h7F);
        idle(2);
        tx_done = 1'b1;
        step();
        chk("nak_deferred", last_wr, 8'h15);
        send(8'h02);
        chk("ack_step", last_wr, 8'h05);

        cpu_cnt = 0;
        for (int k = 0; k < 2; k++) begin
            send(8'h03);
            step();
            idle(3);
            pulse_rg();
        end
        chk("step_cpu_pulses", cpu_cnt, 2);
        for (int k = 0; k < 3; k++) send(8'($urandom_range(255, 5)));

        send(8'h01);
        chk("ack_cont", last_wr, 8'h05);
        cpu_cnt = 0;
        for (int k = 0; k < 6; k++) begin instr = rnd_instr(); step(); end
        instr = HALT;
        step();
        instr = '0;
        chk("halt_run_cycles", cpu_cnt, 7);
        idle(2); pulse_rg(); idle(2); pulse_dm();
        chk("halted_after_dump", int'(o_halted), 1);

        send(8'h33);
        chk("nak_in_done", last_wr, 8'h15);
        send(8'h01);
        chk("reload_load_start", int'(o_load_start), 1);
        idle(2); pulse_ld();
        send(8'h01);
        cpu_cnt = 0; wr_bytes.delete();
        for (int k = 0; k < 24; k++) begin instr = rnd_instr(); step(); end
        chk("wd_run_cycles", cpu_cnt, RL - 1);
        chk("wd_nak_count", wr_bytes.size(), 1);
        if (wr_bytes.size() == 1) chk("wd_nak_byte", wr_bytes[0], 8'h15);
        pulse_rg(); idle(1); pulse_dm();
        chk("halted_after_wd", int'(o_halted), 1);

        for (int k = 0; k < 3000; k++) begin
            rx_done = ($urandom_range(3) == 0);
            case ($urandom_range(5))
                0: rx_data = 8'h01;
                1: rx_data = 8'h02;
                2: rx_data = 8'h03;
                3: rx_data = 8'h04;
                default: rx_data = 8'($urandom);
            endcase
            tx_done = ($urandom_range(3) != 0);
            ld_done = ($urandom_range(5) == 0);
            rg_done = ($urandom_range(5) == 0);
            dm_done = ($urandom_range(5) == 0);
            instr   = ($urandom_range(15) == 0) ? HALT : rnd_instr();
            step();
        end
        rx_done = 1'b0; ld_done = 1'b0; rg_done = 1'b0; dm_done = 1'b0; instr = '0;
        tx_done = 1'b1;

        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        send(8'h01);
        pulse_ld();
        send(8'h01);
        idle(5);
        #3;
        chk("running_before_rst", int'(o_cpu_en), 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_cpu_en", int'(o_cpu_en), 0);
        chk("async_rst_wr", int'(o_wr), 0);
        step();
        rst_n = 1'b1;
        idle(15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
